nv_ram_rd_stream_512x64: RTL



---
 rtl/nv_ram_rd_stream_512x64_if.sv | 40 ++++
 rtl/nv_ram_rd_stream_512x64.sv | 132 +++++++++++++
 2 files changed

// File: rtl/nv_ram_rd_stream_512x64_if.sv
// Command, RAM read port and output stream bundle for nv_ram_rd_stream_512x64.
// stall_cnt exists only when NV_RAM_RD_STREAM_PERF_EN is defined.
interface nv_ram_rd_stream_512x64_if #(
    parameter int AW = 9,
    parameter int DW = 64
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_dout;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
`ifdef NV_RAM_RD_STREAM_PERF_EN
    logic [31:0]   stall_cnt;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_dout, rd_ready,
        output cmd_ready, ram_ra, ram_re, rd_valid, rd_data, rd_last, busy, stall_cnt
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_dout, rd_ready,
        input  cmd_ready, ram_ra, ram_re, rd_valid, rd_data, rd_last, busy, stall_cnt
    );
`else
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_dout, rd_ready,
        output cmd_ready, ram_ra, ram_re, rd_valid, rd_data, rd_last, busy
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_dout, rd_ready,
        input  cmd_ready, ram_ra, ram_re, rd_valid, rd_data, rd_last, busy
    );
`endif
endinterface

// File: rtl/nv_ram_rd_stream_512x64.sv
// Burst read streamer for the 512x64 RAM; optional NV_RAM_RD_STREAM_PERF_EN adds stall_cnt.
// Latency: accept edge -> ram_re next cycle -> rd_valid two cycles later; 1 word/cycle.
// Backpressure: issue stalls so FIFO plus in-flight never exceeds 2 words; head held stable.
module nv_ram_rd_stream_512x64 #(
    parameter int AW         = 9,
    parameter int DW         = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    nv_ram_rd_stream_512x64_if.master    bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_ra;
    logic [AW:0]   r_remaining;
    logic          r_inflight;
    logic          r_inflight_last;

    logic [DW-1:0] r_fifo_dat  [FIFO_DEPTH];
    logic          r_fifo_last [FIFO_DEPTH];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic          w_rd_valid;
    logic          w_pop;
    logic          w_accept;
    logic [2:0]    w_occupancy;
    logic          w_issue;

    assign w_rd_valid  = (r_count != 2'd0) & ~rst;
    assign w_pop       = w_rd_valid & bus.rd_ready;
    assign w_accept    = bus.cmd_valid & bus.cmd_ready;
    // A slot freed by this cycle's pop may be reused by the read issued now.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = ~rst & (r_state == S_RUN) & (r_remaining != '0)
                       & (w_occupancy < 3'(FIFO_DEPTH));

    assign bus.cmd_ready = (r_state == S_IDLE) & ~rst;
    assign bus.ram_re    = w_issue;
    assign bus.ram_ra    = w_issue ? r_addr : r_ra;
    assign bus.rd_valid  = w_rd_valid;
    assign bus.rd_data   = r_fifo_dat[r_rd_ptr];
    assign bus.rd_last   = w_rd_valid & r_fifo_last[r_rd_ptr];
    assign bus.busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_ra            <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_dat[i]  <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= bus.cmd_addr;
                        r_remaining <= {1'b0, bus.cmd_len} + (AW+1)'(1);
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_remaining == '0) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_inflight && (r_count == 2'd0)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Address wraps naturally at the AW-bit boundary (511 -> 0).
            if (w_issue) begin
                r_ra        <= r_addr;
                r_addr      <= r_addr + AW'(1);
                r_remaining <= r_remaining - (AW+1)'(1);
            end

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & (r_remaining == (AW+1)'(1));

            if (r_inflight) begin
                r_fifo_dat[r_wr_ptr]  <= bus.ram_dout;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef NV_RAM_RD_STREAM_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_stall_cnt <= '0;
        end else if (w_rd_valid && !bus.rd_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
